fb_writer: RTL and testbench

Framebuffer write-back engine between the rasterizer output FIFO and the PLB master IPIF. It pops one 96-bit pixel record at a time from a first-word-fall-through FIFO. Each record becomes a single-beat 32-bit PLB master write to the address it carries. Reads are never issued; the read-side IPIF master ports are tied off.

---
 rtl/fb_writer.sv | 118 +++++++++++
 tb/tb_fb_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_writer.sv
// Framebuffer write-back engine: pops one pixel record at a time from a
// first-word-fall-through FIFO. Each record becomes a single-beat 32-bit
// PLB master write. The read side of the master IPIF is tied off.
//
// state         | meaning
// --------------+--------------------------------------------------------
// ST_IDLE       | waiting for a record; pops and captures it when present
// ST_REQ        | write request raised, waiting for CmdAck (or timeout)
// ST_WAIT_CMPLT | command accepted, waiting for Cmplt (or timeout)
module fb_writer (
  input  logic         PLB_clk,
  input  logic         reset,
  input  logic         Bus2IP_Reset,
  input  logic [0:95]  fifo_data,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  output logic         IP2Bus_MstRd_Req,
  output logic         IP2Bus_MstWr_Req,
  output logic [0:31]  IP2Bus_Mst_Addr,
  output logic [0:3]   IP2Bus_Mst_BE,
  output logic         IP2Bus_Mst_Lock,
  output logic         IP2Bus_Mst_Reset,
  input  logic         Bus2IP_Mst_CmdAck,
  input  logic         Bus2IP_Mst_Cmplt,
  input  logic         Bus2IP_Mst_Error,
  input  logic         Bus2IP_Mst_Rearbitrate,
  input  logic         Bus2IP_Mst_Cmd_Timeout,
  input  logic [0:31]  Bus2IP_MstRd_d,
  input  logic         Bus2IP_MstRd_src_rdy_n,
  output logic [0:31]  IP2Bus_MstWr_d,
  input  logic         Bus2IP_MstWr_dst_rdy_n
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQ        = 2'd1,
    ST_WAIT_CMPLT = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [0:29]  addr_q;
  logic [0:31]  data_q;
  logic         capture;
  logic         wr_req;

  // Error only qualifies Cmplt (record is discarded either way), rearbitrate
  // simply leaves the request up, and write data is held for the whole
  // transaction, so these inputs never steer the logic.
  logic unused_inputs;
  assign unused_inputs = ^{Bus2IP_Reset, fifo_data[30:63], Bus2IP_Mst_Error,
                           Bus2IP_Mst_Rearbitrate, Bus2IP_MstRd_d,
                           Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n};

  // State register; reset abandons any outstanding record.
  always_ff @(posedge PLB_clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobes. The pop is gated by reset so nothing is popped
  // while the engine is held in reset even though the state reads IDLE.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    capture    = 1'b0;
    wr_req     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && reset) begin
          fifo_rd_en = 1'b1;
          capture    = 1'b1;
          state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        wr_req = 1'b1;
        // CmdAck wins over a simultaneous timeout.
        if (Bus2IP_Mst_CmdAck) begin
          state_nxt = Bus2IP_Mst_Cmplt ? ST_IDLE : ST_WAIT_CMPLT;
        end else if (Bus2IP_Mst_Cmd_Timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_CMPLT: begin
        if (Bus2IP_Mst_Cmplt || Bus2IP_Mst_Cmd_Timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Record capture; address and data only move on a pop.
  always_ff @(posedge PLB_clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (capture) begin
      addr_q <= fifo_data[0:29];
      data_q <= fifo_data[64:95];
    end
  end

  assign IP2Bus_MstWr_Req  = wr_req;
  assign IP2Bus_Mst_Addr   = {addr_q, 2'b00};
  assign IP2Bus_MstWr_d    = data_q;
  assign IP2Bus_Mst_BE     = 4'b1111;
  assign IP2Bus_MstRd_Req  = 1'b0;
  assign IP2Bus_Mst_Lock   = 1'b0;
  assign IP2Bus_Mst_Reset  = 1'b0;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: single write, streaming with address wrap,
// split ack/complete, rearbitrate/timeout, ack-over-timeout, empty FIFO and
// reset in the middle of a request.
module tb_fb_writer;

  logic         PLB_clk = 1'b0;
  logic         reset;
  logic         Bus2IP_Reset;
  logic [0:95]  fifo_data;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic         IP2Bus_MstRd_Req;
  logic         IP2Bus_MstWr_Req;
  logic [0:31]  IP2Bus_Mst_Addr;
  logic [0:3]   IP2Bus_Mst_BE;
  logic         IP2Bus_Mst_Lock;
  logic         IP2Bus_Mst_Reset;
  logic         Bus2IP_Mst_CmdAck;
  logic         Bus2IP_Mst_Cmplt;
  logic         Bus2IP_Mst_Error;
  logic         Bus2IP_Mst_Rearbitrate;
  logic         Bus2IP_Mst_Cmd_Timeout;
  logic [0:31]  Bus2IP_MstRd_d;
  logic         Bus2IP_MstRd_src_rdy_n;
  logic [0:31]  IP2Bus_MstWr_d;
  logic         Bus2IP_MstWr_dst_rdy_n;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  int p0;

  fb_writer dut (
    .PLB_clk                (PLB_clk),
    .reset                  (reset),
    .Bus2IP_Reset           (Bus2IP_Reset),
    .fifo_data              (fifo_data),
    .fifo_empty             (fifo_empty),
    .fifo_rd_en             (fifo_rd_en),
    .IP2Bus_MstRd_Req       (IP2Bus_MstRd_Req),
    .IP2Bus_MstWr_Req       (IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr        (IP2Bus_Mst_Addr),
    .IP2Bus_Mst_BE          (IP2Bus_Mst_BE),
    .IP2Bus_Mst_Lock        (IP2Bus_Mst_Lock),
    .IP2Bus_Mst_Reset       (IP2Bus_Mst_Reset),
    .Bus2IP_Mst_CmdAck      (Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt       (Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error       (Bus2IP_Mst_Error),
    .Bus2IP_Mst_Rearbitrate (Bus2IP_Mst_Rearbitrate),
    .Bus2IP_Mst_Cmd_Timeout (Bus2IP_Mst_Cmd_Timeout),
    .Bus2IP_MstRd_d         (Bus2IP_MstRd_d),
    .Bus2IP_MstRd_src_rdy_n (Bus2IP_MstRd_src_rdy_n),
    .IP2Bus_MstWr_d         (IP2Bus_MstWr_d),
    .Bus2IP_MstWr_dst_rdy_n (Bus2IP_MstWr_dst_rdy_n)
  );

  always #5 PLB_clk = ~PLB_clk;

  // Pop counter, sampled on the edge that consumes the record.
  always @(posedge PLB_clk) begin
    if (fifo_rd_en) pops++;
  end

  function automatic logic [0:95] rec(input logic [29:0] a, input logic [31:0] d);
    return {a, 34'h0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge PLB_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset                  = 1'b0;
    Bus2IP_Reset           = 1'b0;
    fifo_data              = {~30'd3, 66'h3FFFF_FFFF_FFFF_FFFF};
    fifo_empty             = 1'b0;
    Bus2IP_Mst_CmdAck      = 1'b0;
    Bus2IP_Mst_Cmplt       = 1'b0;
    Bus2IP_Mst_Error       = 1'b0;
    Bus2IP_Mst_Rearbitrate = 1'b0;
    Bus2IP_Mst_Cmd_Timeout = 1'b0;
    Bus2IP_MstRd_d         = 32'hDEADBEEF;
    Bus2IP_MstRd_src_rdy_n = 1'b1;
    Bus2IP_MstWr_dst_rdy_n = 1'b0;

    // Reset held with a non-empty FIFO
    cyc(); cyc();
    chk("rst_rd_en",  {31'b0, fifo_rd_en}, 32'd0);
    chk("rst_req",    {31'b0, IP2Bus_MstWr_Req}, 32'd0);
    chk("rst_addr",   IP2Bus_Mst_Addr, 32'h0);
    chk("rst_data",   IP2Bus_MstWr_d, 32'h0);
    chk("rd_req",     {31'b0, IP2Bus_MstRd_Req}, 32'd0);
    chk("be",         {28'b0, IP2Bus_Mst_BE}, 32'hF);
    chk("lock",       {31'b0, IP2Bus_Mst_Lock}, 32'd0);
    chk("mst_reset",  {31'b0, IP2Bus_Mst_Reset}, 32'd0);

    // Single write
    reset = 1'b1;
    settle();
    chk("single_pop", {31'b0, fifo_rd_en}, 32'd1);
    cyc();
    fifo_empty = 1'b1;
    settle();
    chk("single_req",  {31'b0, IP2Bus_MstWr_Req}, 32'd1);
    chk("single_addr", IP2Bus_Mst_Addr, 32'hFFFFFFF0);
    chk("single_data", IP2Bus_MstWr_d, 32'hFFFFFFFF);
    chk("single_be",   {28'b0, IP2Bus_Mst_BE}, 32'hF);
    chk("single_nopop", {31'b0, fifo_rd_en}, 32'd0);
    Bus2IP_Mst_CmdAck = 1'b1;
    Bus2IP_Mst_Cmplt  = 1'b1;
    cyc();
    Bus2IP_Mst_CmdAck = 1'b0;
    Bus2IP_Mst_Cmplt  = 1'b0;
    settle();
    chk("single_req_low", {31'b0, IP2Bus_MstWr_Req}, 32'd0);
    chk("single_idle_empty", {31'b0, fifo_rd_en}, 32'd0);

    // Streaming, ack+cmplt in first REQ cycle; word address wraps at the end
    fifo_data  = rec(30'h3FFFFFFC, 32'hA0000000);
    fifo_empty = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("stream_pop%0d", i), {31'b0, fifo_rd_en}, 32'd1);
      cyc();
      fifo_data = rec(30'h3FFFFFFC + 30'(i + 1), 32'hA0000000 + 32'(i + 1));
      settle();
      chk($sformatf("stream_req%0d", i), {31'b0, IP2Bus_MstWr_Req}, 32'd1);
      chk($sformatf("stream_addr%0d", i), IP2Bus_Mst_Addr, 32'hFFFFFFF0 + 32'(4 * i));
      chk($sformatf("stream_data%0d", i), IP2Bus_MstWr_d, 32'hA0000000 + 32'(i));
      chk($sformatf("stream_nopop%0d", i), {31'b0, fifo_rd_en}, 32'd0);
      Bus2IP_Mst_CmdAck = 1'b1;
      Bus2IP_Mst_Cmplt  = 1'b1;
      cyc();
      Bus2IP_Mst_CmdAck = 1'b0;
      Bus2IP_Mst_Cmplt  = 1'b0;
    end
    chk("stream_pop_count", 32'(pops - p0), 32'd5);

    // Split ack / complete
    fifo_data = rec(30'h40, 32'h12345678);
    settle();
    chk("split_pop", {31'b0, fifo_rd_en}, 32'd1);
    cyc();
    fifo_data = rec(30'h80, 32'hCAFEF00D);
    Bus2IP_Mst_CmdAck = 1'b1;
    cyc();
    Bus2IP_Mst_CmdAck = 1'b0;
    settle();
    chk("split_req_drop", {31'b0, IP2Bus_MstWr_Req}, 32'd0);
    chk("split_nopop_w0", {31'b0, fifo_rd_en}, 32'd0);
    cyc();
    chk("split_nopop_w1", {31'b0, fifo_rd_en}, 32'd0);
    chk("split_addr_hold", IP2Bus_Mst_Addr, 32'h00000100);
    chk("split_data_hold", IP2Bus_MstWr_d, 32'h12345678);
    cyc();
    chk("split_nopop_w2", {31'b0, fifo_rd_en}, 32'd0);
    Bus2IP_Mst_Cmplt = 1'b1;
    Bus2IP_Mst_Error = 1'b1;
    settle();
    chk("split_nopop_cmplt", {31'b0, fifo_rd_en}, 32'd0);
    cyc();
    Bus2IP_Mst_Cmplt = 1'b0;
    Bus2IP_Mst_Error = 1'b0;
    settle();
    chk("split_pop_after", {31'b0, fifo_rd_en}, 32'd1);

    // Rearbitrate then timeout
    cyc();
    fifo_data = rec(30'h3, 32'h55AA55AA);
    Bus2IP_Mst_Rearbitrate = 1'b1;
    settle();
    chk("rearb_addr", IP2Bus_Mst_Addr, 32'h00000200);
    cyc();
    Bus2IP_Mst_Rearbitrate = 1'b0;
    settle();
    chk("rearb_req_hold", {31'b0, IP2Bus_MstWr_Req}, 32'd1);
    chk("rearb_nopop", {31'b0, fifo_rd_en}, 32'd0);
    Bus2IP_Mst_Cmd_Timeout = 1'b1;
    cyc();
    Bus2IP_Mst_Cmd_Timeout = 1'b0;
    settle();
    chk("tmo_req_low", {31'b0, IP2Bus_MstWr_Req}, 32'd0);
    chk("tmo_next_pop", {31'b0, fifo_rd_en}, 32'd1);

    // Ack and timeout together: ack wins, so WAIT_CMPLT (no pop with FIFO full)
    cyc();
    chk("prec_addr", IP2Bus_Mst_Addr, 32'h0000000C);
    chk("prec_data", IP2Bus_MstWr_d, 32'h55AA55AA);
    Bus2IP_Mst_CmdAck      = 1'b1;
    Bus2IP_Mst_Cmd_Timeout = 1'b1;
    cyc();
    Bus2IP_Mst_CmdAck      = 1'b0;
    Bus2IP_Mst_Cmd_Timeout = 1'b0;
    settle();
    chk("prec_wait_nopop", {31'b0, fifo_rd_en}, 32'd0);
    chk("prec_wait_req", {31'b0, IP2Bus_MstWr_Req}, 32'd0);
    Bus2IP_Mst_Cmplt = 1'b1;
    cyc();
    Bus2IP_Mst_Cmplt = 1'b0;

    // Empty FIFO: nothing happens
    fifo_empty = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("empty_rd_en%0d", i), {31'b0, fifo_rd_en}, 32'd0);
      chk($sformatf("empty_req%0d", i), {31'b0, IP2Bus_MstWr_Req}, 32'd0);
      chk($sformatf("empty_rdreq%0d", i), {31'b0, IP2Bus_MstRd_Req}, 32'd0);
      cyc();
    end

    // Reset mid-request
    fifo_data  = rec(30'h1234567, 32'h0BADCAFE);
    fifo_empty = 1'b0;
    cyc();
    chk("mid_req_up", {31'b0, IP2Bus_MstWr_Req}, 32'd1);
    #2;
    reset = 1'b0;
    settle();
    chk("mid_req_async", {31'b0, IP2Bus_MstWr_Req}, 32'd0);
    chk("mid_addr_async", IP2Bus_Mst_Addr, 32'h0);
    chk("mid_data_async", IP2Bus_MstWr_d, 32'h0);
    chk("mid_rd_en_held", {31'b0, fifo_rd_en}, 32'd0);
    cyc();
    chk("mid_rd_en_held2", {31'b0, fifo_rd_en}, 32'd0);
    reset = 1'b1;
    settle();
    chk("mid_pop_after", {31'b0, fifo_rd_en}, 32'd1);
    cyc();
    fifo_empty = 1'b1;
    settle();
    chk("mid_req_again", {31'b0, IP2Bus_MstWr_Req}, 32'd1);
    chk("mid_addr_again", IP2Bus_Mst_Addr, 32'h048D159C);
    chk("mid_data_again", IP2Bus_MstWr_d, 32'h0BADCAFE);
    Bus2IP_Mst_CmdAck = 1'b1;
    Bus2IP_Mst_Cmplt  = 1'b1;
    cyc();
    Bus2IP_Mst_CmdAck = 1'b0;
    Bus2IP_Mst_Cmplt  = 1'b0;
    settle();
    chk("mid_done", {31'b0, IP2Bus_MstWr_Req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
